bilateral_3x3: RTL and testbench

//  Streaming 3x3 edge-preserving bilateral filter for 8-bit grayscale video, raster order.

---
 rtl/bilateral_3x3.sv | 269 ++++++++++++++++++++++++++
 tb/tb_bilateral_3x3.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bilateral_3x3.sv
// bilateral_3x3: streaming 3x3 edge-preserving bilateral filter, 8-bit grayscale, raster order.
// Latency: 4 clk from the edge that accepts pixel (row,col) to bilat_valid for centre (row-1,col-1).
// Backpressure: none; accepts one pixel per clk when gray_valid, gaps of any length allowed.
//
// Ports:
//   clk, rst                     rising-edge clock, asynchronous active-low reset (0 = reset)
//   gray_valid, gray             input pixel stream (8-bit)
//   bilat_valid, bilat_out       filtered centre pixel, one-cycle valid pulse
//   center_row_s1, center_col_s1 coordinates of the pixel in bilat_out
//
// Build option: define BILAT_ROUND_EN for round-half-up normalisation; the default build truncates.
// Line-buffer RAM carries no reset; its stale contents are never used for an emitted result.

module bilateral_3x3 #(
  parameter int IMAGE_WIDTH = 320,
  parameter int COORD_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               gray_valid,
  input  logic [7:0]         gray,
  output logic               bilat_valid,
  output logic [7:0]         bilat_out,
  output logic [COORD_W-1:0] center_row_s1,
  output logic [COORD_W-1:0] center_col_s1
);

  localparam int                 AW       = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(IMAGE_WIDTH - 1);
  localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
  localparam logic [COORD_W-1:0] TWO      = COORD_W'(2);

  // ---------------------------------------------------------------------------
  // Weight functions
  // ---------------------------------------------------------------------------
  function automatic logic [4:0] range_wt(input logic [7:0] p, input logic [7:0] c);
    logic [7:0] d;
    d = (p > c) ? (p - c) : (c - p);
    if (d < 8'd8)       return 5'd16;
    else if (d < 8'd16) return 5'd8;
    else if (d < 8'd32) return 5'd4;
    else if (d < 8'd64) return 5'd2;
    else                return 5'd1;
  endfunction

  function automatic logic [2:0] spatial_wt(input int r, input int c);
    if (r == 1 && c == 1)      return 3'd4;
    else if (r == 1 || c == 1) return 3'd2;
    else                       return 3'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Raster position of the pixel being accepted this cycle
  // ---------------------------------------------------------------------------
  logic [COORD_W-1:0] col_q, col_d;
  logic [COORD_W-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (gray_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + ONE;   // wraps modulo 2^COORD_W, no frame notion
      end else begin
        col_d = col_q + ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers: lb1 holds row-1, lb2 holds row-2 at the current column.
  // Read-before-write on the same address shifts each column down one row.
  // ---------------------------------------------------------------------------
  logic [AW-1:0] lb_addr;
  logic [7:0]    lb1_mem [IMAGE_WIDTH];
  logic [7:0]    lb2_mem [IMAGE_WIDTH];
  logic [7:0]    lb1_rd;
  logic [7:0]    lb2_rd;

  assign lb_addr = col_q[AW-1:0];
  assign lb1_rd  = lb1_mem[lb_addr];
  assign lb2_rd  = lb2_mem[lb_addr];

  always_ff @(posedge clk) begin
    if (gray_valid) begin
      lb1_mem[lb_addr] <= gray;
      lb2_mem[lb_addr] <= lb1_rd;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: 3x3 window, [0]=oldest row/column, [2]=newest. Centre is [1][1].
  // ---------------------------------------------------------------------------
  logic [7:0]         win_q [3][3];
  logic               v1_q;
  logic               v1_d;
  logic [COORD_W-1:0] row1_q, col1_q;

  // Columns 0/1 hold pixels left over from the previous row, rows 0/1 lack
  // two history lines: neither may produce a result.
  assign v1_d = gray_valid && (row_q >= TWO) && (col_q >= TWO);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q  <= '0;
      row_q  <= '0;
      v1_q   <= 1'b0;
      row1_q <= '0;
      col1_q <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      v1_q  <= v1_d;
      if (gray_valid) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb2_rd;
        win_q[1][2] <= lb1_rd;
        win_q[2][2] <= gray;
        row1_q      <= row_q - ONE;
        col1_q      <= col_q - ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: per-tap weight w = ws*wr (max 64, 7 bits)
  // ---------------------------------------------------------------------------
  logic [6:0]         w_d   [9];
  logic [6:0]         w2_q  [9];
  logic [7:0]         p2_q  [9];
  logic               v2_q;
  logic [COORD_W-1:0] row2_q, col2_q;

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w_d[r*3+c] = 7'(spatial_wt(r, c)) * 7'(range_wt(win_q[r][c], win_q[1][1]));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2_q   <= 1'b0;
      row2_q <= '0;
      col2_q <= '0;
      for (int i = 0; i < 9; i++) begin
        w2_q[i] <= '0;
        p2_q[i] <= '0;
      end
    end else begin
      v2_q   <= v1_q;
      row2_q <= row1_q;
      col2_q <= col1_q;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          w2_q[r*3+c] <= w_d[r*3+c];
          p2_q[r*3+c] <= win_q[r][c];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: num = sum w*p (max 256*255, 17 bits), sumw = sum w (9 bits)
  // ---------------------------------------------------------------------------
  logic [16:0]        num_d, num3_q;
  logic [8:0]         sumw_d, sumw3_q;
  logic               v3_q;
  logic [COORD_W-1:0] row3_q, col3_q;

  always_comb begin
    num_d  = '0;
    sumw_d = '0;
    for (int i = 0; i < 9; i++) begin
      num_d  = num_d + (17'(w2_q[i]) * 17'(p2_q[i]));
      sumw_d = sumw_d + 9'(w2_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num3_q  <= '0;
      sumw3_q <= '0;
      v3_q    <= 1'b0;
      row3_q  <= '0;
      col3_q  <= '0;
    end else begin
      num3_q  <= num_d;
      sumw3_q <= sumw_d;
      v3_q    <= v2_q;
      row3_q  <= row2_q;
      col3_q  <= col2_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 4: normalise. The centre tap alone gives sumw >= 64 for real data;
  // sumw is only zero for the all-zero post-reset bubble, so the divisor is
  // forced to 1 there to keep the divider output defined.
  // ---------------------------------------------------------------------------
  logic [16:0]        dividend_d, divisor_d, quo_d, quo4_q;
  logic               v4_q;
  logic [COORD_W-1:0] row4_q, col4_q;

  always_comb begin
`ifdef BILAT_ROUND_EN
    dividend_d = num3_q + 17'(sumw3_q >> 1);
`else
    dividend_d = num3_q;
`endif
    divisor_d  = (sumw3_q == '0) ? 17'd1 : 17'(sumw3_q);
    quo_d      = dividend_d / divisor_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo4_q <= '0;
      v4_q   <= 1'b0;
      row4_q <= '0;
      col4_q <= '0;
    end else begin
      quo4_q <= quo_d;
      v4_q   <= v3_q;
      row4_q <= row3_q;
      col4_q <= col3_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 5: clamp and register outputs; data holds while no result is valid.
  // ---------------------------------------------------------------------------
  logic               out_vld_q;
  logic [7:0]         out_dat_q, out_dat_d;
  logic [COORD_W-1:0] out_row_q, out_col_q;

  assign out_dat_d = (quo4_q > 17'd255) ? 8'hFF : quo4_q[7:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      out_row_q <= '0;
      out_col_q <= '0;
    end else begin
      out_vld_q <= v4_q;
      if (v4_q) begin
        out_dat_q <= out_dat_d;
        out_row_q <= row4_q;
        out_col_q <= col4_q;
      end
    end
  end

  assign bilat_valid   = out_vld_q;
  assign bilat_out     = out_dat_q;
  assign center_row_s1 = out_row_q;
  assign center_col_s1 = out_col_q;

endmodule

// File: tb/tb_bilateral_3x3.sv
// tb_bilateral_3x3: directed checks of bilateral_3x3 (window vectors, frames, coords, reset).
// Latency: results gathered by a negedge monitor, compared after each stream drains.
// Backpressure: none; the bench drives pixels back-to-back or with fixed gaps.

module tb_bilateral_3x3;

  localparam int W  = 320;
  localparam int CW = 16;
`ifdef BILAT_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          gray_valid = 1'b0;
  logic [7:0]    gray = 8'd0;
  logic          bilat_valid;
  logic [7:0]    bilat_out;
  logic [CW-1:0] center_row_s1;
  logic [CW-1:0] center_col_s1;

  bilateral_3x3 #(.IMAGE_WIDTH(W), .COORD_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .gray_valid    (gray_valid),
    .gray          (gray),
    .bilat_valid   (bilat_valid),
    .bilat_out     (bilat_out),
    .center_row_s1 (center_row_s1),
    .center_col_s1 (center_col_s1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int val; int row; int col; int cyc; } res_t;
  res_t res_q[$];
  res_t mon_r;

  always @(negedge clk) begin
    if (bilat_valid) begin
      mon_r.val = int'(bilat_out);
      mon_r.row = int'(center_row_s1);
      mon_r.col = int'(center_col_s1);
      mon_r.cyc = cyc;
      res_q.push_back(mon_r);
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  logic [7:0] frm [4][W];
  int last_cyc = 0;
  int e0_22    = 0;

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input logic [7:0] v);
    gray       = v;
    gray_valid = 1'b1;
    @(posedge clk);
    #1;
    last_cyc   = cyc;
    gray_valid = 1'b0;
  endtask

  task automatic send_frame(input int nrows, input int gap);
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < W; c++) begin
        send_pix(frm[r][c]);
        if (r == 2 && c == 2) e0_22 = last_cyc;
        if (gap > 0) idle(gap);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(2);
  endtask

  // Reference bilateral value for centre (r,c) of frm.
  function automatic int ref_pix(input int r, input int c);
    int cp, p, d, wr, ws, sw, nm;
    cp = int'(frm[r][c]);
    sw = 0;
    nm = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        p  = int'(frm[r+dy][c+dx]);
        d  = (p > cp) ? p - cp : cp - p;
        wr = (d < 8) ? 16 : (d < 16) ? 8 : (d < 32) ? 4 : (d < 64) ? 2 : 1;
        ws = (dy == 0 && dx == 0) ? 4 : (dy == 0 || dx == 0) ? 2 : 1;
        sw += ws * wr;
        nm += ws * wr * p;
      end
    end
    return ROUND ? (nm + sw / 2) / sw : nm / sw;
  endfunction

  task automatic compare_model(input string nm);
    int idx;
    idx = 0;
    check({nm, "_count"}, res_q.size(), (W - 2) * 2);
    for (int r = 1; r <= 2; r++) begin
      for (int c = 1; c <= W - 2; c++) begin
        if (idx < res_q.size()) begin
          check({nm, "_val"},   res_q[idx].val, ref_pix(r, c));
          check({nm, "_coord"}, res_q[idx].row * 65536 + res_q[idx].col, r * 65536 + c);
        end
        idx++;
      end
    end
  endtask

  function automatic int find_val(input int r, input int c);
    foreach (res_q[i]) begin
      if (res_q[i].row == r && res_q[i].col == c) return res_q[i].val;
    end
    return -1;
  endfunction

  // Window vectors: p00..p22 row-major, expected truncated / rounded result.
  typedef struct { string name; logic [71:0] win; int exp_trn; int exp_rnd; } vec_t;
  vec_t vecs [9];

  task automatic set_vec(input int k, input string nm, input logic [71:0] w, input int et, input int er);
    vecs[k].name    = nm;
    vecs[k].win     = w;
    vecs[k].exp_trn = et;
    vecs[k].exp_rnd = er;
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int nbad;
    logic [71:0] wv;

    set_vec(0, "flat",       {9{8'd100}},                                   100, 100);
    set_vec(1, "ctr50_nb200", {{4{8'd200}}, 8'd50,  {4{8'd200}}},           73,  74);
    set_vec(2, "ctr100_nb104",{{4{8'd104}}, 8'd100, {4{8'd104}}},           103, 103);
    set_vec(3, "ctr0_nb255",  {{4{8'd255}}, 8'd0,   {4{8'd255}}},           40,  40);
    set_vec(4, "ctr255_nb0",  {{4{8'd0}},   8'd255, {4{8'd0}}},             214, 215);
    set_vec(5, "thresholds",  {8'd115, 8'd92, 8'd130, 8'd84, 8'd100, 8'd68,
                               8'd163, 8'd37, 8'd164},                      98,  98);
    set_vec(6, "step",        {8'd10, 8'd200, 8'd210, 8'd10, 8'd200, 8'd210,
                               8'd10, 8'd200, 8'd210},                      197, 197);
    set_vec(7, "d8_edge",     {{4{8'd8}}, 8'd0, {4{8'd8}}},                 4,   5);
    set_vec(8, "d7_edge",     {{4{8'd7}}, 8'd0, {4{8'd7}}},                 5,   5);

    // ---- reset state ----
    idle(3);
    check("rst_valid", 32'(bilat_valid), 0);
    check("rst_out",   32'(bilat_out), 0);
    check("rst_row",   32'(center_row_s1), 0);
    check("rst_col",   32'(center_col_s1), 0);
    rst = 1'b1;
    idle(2);

    // ---- flat 320x4 frame, back-to-back ----
    for (int r = 0; r < 4; r++) for (int c = 0; c < W; c++) frm[r][c] = 8'd100;
    res_q.delete();
    send_frame(4, 0);
    idle(10);
    check("flat_count", res_q.size(), 636);
    if (res_q.size() > 0) begin
      check("flat_first_row", res_q[0].row, 1);
      check("flat_first_col", res_q[0].col, 1);
      check("flat_latency",   res_q[0].cyc - e0_22, 4);
      check("flat_last_row",  res_q[res_q.size()-1].row, 2);
      check("flat_last_col",  res_q[res_q.size()-1].col, W - 2);
    end
    nbad = 0;
    foreach (res_q[i]) if (res_q[i].val != 100) nbad++;
    check("flat_bad_values", nbad, 0);
    check("hold_valid", 32'(bilat_valid), 0);
    check("hold_out",   32'(bilat_out), 100);
    check("hold_row",   32'(center_row_s1), 2);
    check("hold_col",   32'(center_col_s1), W - 2);

    // ---- window vector table, vector k centred at (1, 3k+1) ----
    do_reset();
    for (int r = 0; r < 3; r++) for (int c = 0; c < W; c++) frm[r][c] = 8'd0;
    for (int k = 0; k < 9; k++) begin
      wv = vecs[k].win;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          frm[r][3*k+c] = wv[8*(8-(3*r+c)) +: 8];
    end
    res_q.delete();
    send_frame(3, 0);
    idle(10);
    check("vec_count", res_q.size(), W - 2);
    for (int k = 0; k < 9; k++) begin
      check({"vec_", vecs[k].name}, find_val(1, 3*k+1),
            ROUND ? vecs[k].exp_rnd : vecs[k].exp_trn);
    end

    // ---- random 320x4 frame: back-to-back then sparse ----
    for (int r = 0; r < 4; r++) for (int c = 0; c < W; c++) frm[r][c] = 8'($urandom_range(0, 255));
    do_reset();
    res_q.delete();
    send_frame(4, 0);
    idle(10);
    compare_model("b2b");
    do_reset();
    res_q.delete();
    send_frame(4, 10);
    idle(10);
    compare_model("sparse");
    if (res_q.size() > 0) begin
      check("last_tag_row", res_q[res_q.size()-1].row, 2);
      check("last_tag_col", res_q[res_q.size()-1].col, W - 2);
    end

    // ---- reset mid row 2 ----
    for (int r = 0; r < 4; r++) for (int c = 0; c < W; c++) frm[r][c] = 8'd60;
    do_reset();
    send_frame(2, 0);
    for (int c = 0; c < 10; c++) send_pix(frm[2][c]);
    check("pre_rst_valid", 32'(bilat_valid), 1);
    rst = 1'b0;
    res_q.delete();
    #1;
    check("midrst_valid", 32'(bilat_valid), 0);
    check("midrst_out",   32'(bilat_out), 0);
    idle(8);
    check("midrst_no_out", res_q.size(), 0);
    rst = 1'b1;
    idle(2);
    send_frame(2, 0);
    send_pix(frm[2][0]);
    send_pix(frm[2][1]);
    idle(8);
    check("post_rst_quiet", res_q.size(), 0);
    send_pix(frm[2][2]);
    e0_22 = last_cyc;
    idle(8);
    check("post_rst_count", res_q.size(), 1);
    if (res_q.size() > 0) begin
      check("post_rst_row",     res_q[0].row, 1);
      check("post_rst_col",     res_q[0].col, 1);
      check("post_rst_latency", res_q[0].cyc - e0_22, 4);
      check("post_rst_val",     res_q[0].val, 60);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
